score_display_driver: RTL

- Multi-digit decimal display driver for the score/lives readouts on the board's seven-segment bank.
- Accepts a binary value via a load handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Drives NUM_DIGITS active-low seven-segment outputs, with optional leading-zero blanking, overflow saturation and whole-display blinking (e.g. game-over flash).

---
 rtl/score_display_driver.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/score_display_driver.sv
// Score/lives readout driver: binary value -> BCD via a bit-serial double-dabble engine,
// then active-low seven-segment digits with leading-zero blanking, saturation and blinking.
module score_display_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_WIDTH  = 14,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [BIN_WIDTH-1:0]    value,
   input  logic                    load,
   input  logic                    blank_zeros,
   input  logic                    blink_en,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] hex_out
);

   // Enough BCD digits to hold any BIN_WIDTH-bit value, so the accumulator never wraps.
   localparam int BCD_DIGITS = (NUM_DIGITS > (BIN_WIDTH + 2) / 3) ? NUM_DIGITS : (BIN_WIDTH + 2) / 3;
   localparam int BCD_W      = 4 * BCD_DIGITS;
   localparam int DISP_W     = 4 * NUM_DIGITS;
   localparam int CNT_W      = $clog2(BIN_WIDTH + 1);
   localparam int BLK_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   function automatic longint max_display();
      longint m = 1;
      for (int i = 0; i < NUM_DIGITS; i++) m = m * 10;
      return m - 1;
   endfunction

   localparam longint MAX_VAL = max_display();

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE} state_e;

   state_e               state_q, state_d;
   logic [BIN_WIDTH-1:0] bin_q, bin_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ovf_cap_q, ovf_cap_d;
   logic [DISP_W-1:0]    disp_q, disp_d;
   logic                 overflow_q, overflow_d;
   logic                 done_q, done_d;
   logic [BLK_W-1:0]     blink_cnt_q;
   logic                 blink_off_q;

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next-state logic ----------------
   // NOTE: the default assignment first keeps this combinational block free of inferred latches.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (load) state_d = S_SHIFT;
         S_SHIFT:  if (cnt_q == CNT_W'(1)) state_d = S_UPDATE;
         S_UPDATE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy     = (state_q != S_IDLE);
      done     = done_q;
      overflow = overflow_q;
   end

   // ---------------- Conversion datapath ----------------
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_cap_d  = ovf_cap_q;
      disp_d     = disp_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               bin_d     = value;
               bcd_d     = '0;
               cnt_d     = CNT_W'(BIN_WIDTH);
               ovf_cap_d = (64'(value) > MAX_VAL);
            end
         end
         S_SHIFT: begin
            bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
         end
         S_UPDATE: begin
            disp_d     = ovf_cap_q ? {NUM_DIGITS{4'd9}} : bcd_q[DISP_W-1:0];
            overflow_d = ovf_cap_q;
            done_d     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_cap_q  <= 1'b0;
         disp_q     <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_cap_q  <= ovf_cap_d;
         disp_q     <= disp_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   // ---------------- Blink timebase ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
      end else if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
         blink_cnt_q <= '0;
         blink_off_q <= ~blink_off_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BLK_W'(1);
      end
   end

   // ---------------- Segment output ----------------
   logic       zero_run;
   logic [3:0] digit;

   // Scan from the most significant digit so zero_run means "this and every digit above is 0".
   always_comb begin
      hex_out  = '1;
      zero_run = 1'b1;
      digit    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         digit    = disp_q[4*i +: 4];
         zero_run = zero_run & (digit == 4'd0);
         if (!((blink_en && blink_off_q) || (blank_zeros && zero_run && (i != 0))))
            hex_out[7*i +: 7] = seg7(digit);
      end
   end

endmodule
